// File: rtl/lf_pkg.sv
// Shared types for the carry-lookahead adder pipeline: operand width and the
// per-beat propagate/generate bundle handed from one prefix level to the next.
package lf_pkg;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] hsum;
    logic             cin;
  } pg_beat_t;

endpackage

// File: rtl/pg_cell.sv
// One-bit propagate/generate cell. The FOLD instance (bit 0) absorbs the adder
// carry-in into its generate and reports no propagate.
module pg_cell #(
  parameter bit FOLD = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic p,
  output logic g,
  output logic h
);

  // Bit-level half-add terms with optional carry-in fold.
  always_comb begin
    h = a ^ b;
    if (FOLD) begin
      g = (a & b) | (h & cin);
      p = 1'b0;
    end else begin
      g = a & b;
      p = h;
    end
  end

endmodule

// File: rtl/pg_stage.sv
// First adder stage: builds per-bit propagate/generate and buffers them behind a
// valid/ready interface with a main register and a one-entry skid register.
module pg_stage
  import lf_pkg::*;
#(
  parameter int WIDTH = lf_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_list,
  output logic [WIDTH-1:0] g_list,
  output logic [WIDTH-1:0] hsum,
  output logic             cin_q,
  output logic [15:0]      beat_cnt
);

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] h_s;
  pg_beat_t         beat_s;

  pg_beat_t    main_q, main_d;
  pg_beat_t    skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic        in_hs_s;
  logic        out_hs_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    pg_cell #(.FOLD(i == 0)) u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin ((i == 0) ? cin : 1'b0),
      .p   (p_s[i]),
      .g   (g_s[i]),
      .h   (h_s[i])
    );
  end

  // Pack the freshly computed terms into one beat.
  always_comb begin
    beat_s      = '0;
    beat_s.p    = p_s;
    beat_s.g    = g_s;
    beat_s.hsum = h_s;
    beat_s.cin  = cin;
  end

  // Next-state for main/skid buffers, ready flag and handshake counter.
  always_comb begin
    in_hs_s      = in_valid & in_ready_q;
    out_hs_s     = main_valid_q & out_ready;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    beat_cnt_d   = beat_cnt_q;
    in_ready_d   = in_ready_q;
    if (rst) begin
      main_d       = '0;
      skid_d       = '0;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      beat_cnt_d   = 16'h0000;
      in_ready_d   = 1'b0;
    end else begin
      if (out_hs_s) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end else begin
        beat_cnt_d = beat_cnt_q;
      end
      // in_ready_q is low while the skid holds data, so no input can race the refill.
      if (!main_valid_q || out_ready) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_hs_s) begin
          main_d       = beat_s;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else begin
        if (in_hs_s) begin
          skid_d       = beat_s;
          skid_valid_d = 1'b1;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end
      in_ready_d = !skid_valid_d;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    main_q       <= main_d;
    skid_q       <= skid_d;
    main_valid_q <= main_valid_d;
    skid_valid_q <= skid_valid_d;
    beat_cnt_q   <= beat_cnt_d;
    in_ready_q   <= in_ready_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign p_list    = main_q.p;
  assign g_list    = main_q.g;
  assign hsum      = main_q.hsum;
  assign cin_q     = main_q.cin;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_pg_stage.sv
// Scoreboard bench for pg_stage: expected beats queued at input handshakes and
// compared in order at output handshakes; stalls checked for stable outputs.
module tb_pg_stage;
  import lf_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p_list;
  logic [31:0] g_list;
  logic [31:0] hsum;
  logic        cin_q;
  logic [15:0] beat_cnt;

  pg_stage #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_list    (p_list),
    .g_list    (g_list),
    .hsum      (hsum),
    .cin_q     (cin_q),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_cmp = 0;
  int       n_bad = 0;
  int       pushed = 0;
  int       popped = 0;
  pg_beat_t sb_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic pg_beat_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    pg_beat_t r;
    r.hsum = x ^ y;
    r.p    = x ^ y;
    r.p[0] = 1'b0;
    r.g    = x & y;
    r.g[0] = (x[0] & y[0]) | ((x[0] ^ y[0]) & c);
    r.cin  = c;
    return r;
  endfunction

  // One clock: account for handshakes, advance, verify stall stability.
  task automatic tick();
    logic     in_hs;
    logic     out_hs;
    logic     stalled;
    pg_beat_t held;
    pg_beat_t e;
    in_hs   = in_valid && in_ready && !rst;
    out_hs  = out_valid && out_ready && !rst;
    stalled = out_valid && !out_ready && !rst;
    held    = '{p: p_list, g: g_list, hsum: hsum, cin: cin_q};
    if (out_hs) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 128'd1, 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("beat", {31'd0, held}, {31'd0, e});
        popped++;
      end
    end
    if (in_hs) begin
      sb_q.push_back(model(a, b, cin));
      pushed++;
    end
    @(posedge clk);
    #1;
    if (stalled) begin
      check("stall_valid", {127'd0, out_valid}, 128'd1);
      check("stall_hold", {31'd0, p_list, g_list, hsum, cin_q}, {31'd0, held});
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) tick();
    check(tag, 128'(sb_q.size()), 128'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; cin = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_beat_cnt", {112'd0, beat_cnt}, 128'd0);
    check("rst_data", {31'd0, p_list, g_list, hsum, cin_q}, 128'd0);
    rst = 1'b0;
    tick();
    check("rst_in_ready_rise", {127'd0, in_ready}, 128'd1);

    // Carry chain operand: all-ones plus one.
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d36_valid", {127'd0, out_valid}, 128'd1);
    check("d36_g", {96'd0, g_list}, {96'd0, 32'h0000_0001});
    check("d36_p", {96'd0, p_list}, {96'd0, 32'hFFFF_FFFE});
    check("d36_h", {96'd0, hsum}, {96'd0, 32'hFFFF_FFFE});
    tick();

    // Carry-in fold into bit 0.
    in_valid = 1'b1; a = 32'h0000_0001; b = 32'h0000_0000; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    check("d37_g0", {127'd0, g_list[0]}, 128'd1);
    check("d37_p0", {127'd0, p_list[0]}, 128'd0);
    check("d37_h", {96'd0, hsum}, {96'd0, 32'h0000_0001});
    check("d37_cin", {127'd0, cin_q}, 128'd1);
    tick();

    // Back-pressure fills main then skid.
    out_ready = 1'b0; in_valid = 1'b1; b = 32'd0; cin = 1'b0; a = 32'h11;
    tick();
    a = 32'h22;
    tick();
    in_valid = 1'b0;
    check("d38_in_ready_low", {127'd0, in_ready}, 128'd0);
    check("d38_first_h", {96'd0, hsum}, {96'd0, 32'h11});
    tick();
    check("d38_stall_h", {96'd0, hsum}, {96'd0, 32'h11});
    out_ready = 1'b1;
    tick();
    check("d38_second_h", {96'd0, hsum}, {96'd0, 32'h22});
    check("d38_second_valid", {127'd0, out_valid}, 128'd1);
    check("d38_in_ready_rise", {127'd0, in_ready}, 128'd1);
    tick();
    check("d38_empty", {127'd0, out_valid}, 128'd0);
    check("d38_cnt", {112'd0, beat_cnt}, 128'(popped));

    // Random valid/ready traffic.
    begin
      int target;
      target = pushed + 10000;
      for (int i = 0; i < 40000 && pushed < target; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        a   = $urandom;
        b   = $urandom;
        cin = 1'(($urandom & 1));
        tick();
      end
      check("rand_pushed", 128'(pushed), 128'(target));
    end
    drain("rand_drain");
    check("rand_cnt", {112'd0, beat_cnt}, 128'(popped & 16'hFFFF));

    // Stream up to the counter wrap point.
    out_ready = 1'b1;
    for (int i = 0; i < 70000 && (popped + sb_q.size()) < 65535; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; cin = 1'(($urandom & 1));
      tick();
    end
    drain("fill_drain");
    check("cnt_ffff", {112'd0, beat_cnt}, {112'd0, 16'hFFFF});
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1;
    tick();
    drain("wrap_drain");
    check("cnt_wrap", {112'd0, beat_cnt}, 128'd0);

    // Reset with main and skid occupied.
    out_ready = 1'b0; in_valid = 1'b1; a = 32'hAA; b = 32'h55; cin = 1'b0;
    tick();
    a = 32'hBB;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", {126'd0, out_valid, in_ready}, {126'd0, 2'b10});
    rst = 1'b1;
    tick();
    sb_q.delete();
    check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_cnt", {112'd0, beat_cnt}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_beat", {127'd0, out_valid}, 128'd0);
      tick();
    end
    check("post_rst_cnt", {112'd0, beat_cnt}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pg_stage.md
PG_STAGE -- requirements
Module: pg_stage

Interface
REQ-001 Parameter: WIDTH, 32, operand width; SHALL equal the prefix-level input width consumed downstream.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream operand pair valid.
REQ-005 Port: in_ready  output  1  block can accept an operand pair this cycle.
REQ-006 Port: a  input  WIDTH  addend A.
REQ-007 Port: b  input  WIDTH  addend B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  p_list/g_list/hsum/cin_q valid.
REQ-010 Port: out_ready  input  1  downstream prefix tree accepts this cycle.
REQ-011 Port: p_list  output  WIDTH  group propagate per bit; feeds first prefix level.
REQ-012 Port: g_list  output  WIDTH  group generate per bit, carry-in folded into bit 0.
REQ-013 Port: hsum  output  WIDTH  raw a^b, retained for final sum XOR.
REQ-014 Port: cin_q  output  1  registered carry-in matching the output beat.
REQ-015 Port: beat_cnt  output  16  count of completed output handshakes.

Function
REQ-016 Per bit i: p_list[i] SHALL be a[i]^b[i]; g_list[i] SHALL be a[i]&b[i], except g_list[0] SHALL be (a[0]&b[0]) | ((a[0]^b[0])&cin).
REQ-017 p_list[0] SHALL be 0 whenever g_list[0] carries the folded carry-in.
REQ-018 hsum SHALL equal a^b unmodified, including bit 0.
REQ-019 Input handshake: a transfer occurs when in_valid&in_ready is high at a rising edge; output handshake: out_valid&out_ready.
REQ-020 Storage: one output register (main) plus one skid register, each holding {p,g,hsum,cin} and a valid bit.
REQ-021 Latency: an accepted operand with an empty or draining main SHALL appear on outputs the next cycle (1-cycle latency).
REQ-022 in_ready SHALL be registered and equal !skid_valid; no combinational path from out_ready to in_ready.
REQ-023 Main empty or draining, input accepted: result loads main.
REQ-024 Main full and stalled (out_valid & !out_ready), input accepted: result loads skid; in_ready drops the next cycle.
REQ-025 Skid full and main drains: skid moves to main the same edge; skid empties; in_ready rises the next cycle.
REQ-026 Skid full, main drains, and an input arrives the same cycle: cannot occur because in_ready is 0; in_valid is ignored when in_ready is 0.
REQ-027 While stalled, p_list/g_list/hsum/cin_q/out_valid SHALL hold stable.
REQ-028 Ordering SHALL be strictly FIFO; no beat dropped or duplicated.
REQ-029 beat_cnt SHALL increment by 1 per output handshake and wrap from 0xFFFF to 0x0000.

Reset
REQ-030 While rst is high at a clock edge: out_valid=0, skid valid=0, in_ready=0, beat_cnt=0, p_list/g_list/hsum=0, cin_q=0.
REQ-031 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard main and skid contents; no beat is emitted after rst.

Structure
REQ-033 Shared package lf_pkg SHALL hold the WIDTH constant and a packed pg_beat_t struct {p, g, hsum, cin}, reused by the prefix levels.
REQ-034 Bitwise p/g generation SHALL be a sub-module pg_cell (combinational, one bit), instantiated WIDTH times with bit 0 carrying the cin fold.
REQ-035 Handshake and skid control SHALL live in pg_stage only.

Verification
REQ-036 a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> next cycle g_list=0x00000001, p_list=0xFFFFFFFE, hsum=0xFFFFFFFE, out_valid=1.
REQ-037 a=0x00000001, b=0x00000000, cin=1 -> g_list[0]=1, p_list[0]=0, hsum=0x00000001, cin_q=1.
REQ-038 Hold out_ready=0; push 2 beats (A=0x11, A=0x22) -> in_ready=0 after the second; release out_ready -> outputs 0x11 then 0x22 in consecutive cycles; in_ready re-rises.
REQ-039 Random in_valid/out_ready toggling, 10,000 beats -> output sequence matches an input-order scoreboard; outputs stable during every stall.
REQ-040 Preload beat_cnt to 0xFFFF via 65,535 beats, then one more handshake -> beat_cnt=0x0000.
REQ-041 Assert rst with main and skid full -> next cycle out_valid=0, beat_cnt=0; cycle after rst drops in_ready=1, no stale beat emitted.
